// File: rtl/usb_tx_packet_ctrl_if.sv
// Handshake/control bundle between the USB TX packet sequencer, the
// protocol/FIFO layer above it and the byte transmitter below it.
// The optional tx_abort signal exists only when USB_TX_ABORT_EN is defined.
interface usb_tx_packet_ctrl_if;
    // upstream request / FIFO side
    logic        tx_start;
    logic [3:0]  tx_pid;
    logic [6:0]  tx_len;
    logic [7:0]  fifo_byte;
    logic        fifo_rd;
    logic        tx_busy;
    logic        tx_done;
`ifdef USB_TX_ABORT_EN
    logic        tx_abort;
`endif
    // downstream byte transmitter side
    logic        byte_done;
    logic [1:0]  select;
    logic [7:0]  fsm_byte;
    logic [15:0] crc_bytes;
    logic        load_en;
    logic        tim_rst;
    logic        tim_en;
    logic        eop;
    logic        idle;
    logic        eop_new_bit;

    // sequencer side
    modport master (
`ifdef USB_TX_ABORT_EN
        input  tx_abort,
`endif
        input  tx_start, tx_pid, tx_len, fifo_byte, byte_done,
        output fifo_rd, tx_busy, tx_done, select, fsm_byte, crc_bytes,
        output load_en, tim_rst, tim_en, eop, idle, eop_new_bit
    );

    // environment side (protocol layer + byte transmitter)
    modport slave (
`ifdef USB_TX_ABORT_EN
        output tx_abort,
`endif
        output tx_start, tx_pid, tx_len, fifo_byte, byte_done,
        input  fifo_rd, tx_busy, tx_done, select, fsm_byte, crc_bytes,
        input  load_en, tim_rst, tim_en, eop, idle, eop_new_bit
    );
endinterface

// File: rtl/usb_tx_packet_ctrl.sv
// USB transmit packet sequencer: frames SYNC, PID, optional payload from the
// TX FIFO, CRC16, then EOP (2 bit times of SE0) and 1 bit time of J.
// select always names the byte the transmitter loads on the next byte_done.
// Optional feature macro: USB_TX_ABORT_EN (adds tx_abort, jumps to EOP).
module usb_tx_packet_ctrl #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_LEN      = 64
) (
    input logic                  clk,
    input logic                  rst,
    usb_tx_packet_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SYNC, S_PID, S_DATA, S_CRCL, S_LAST, S_EOP, S_J
    } state_t;

    localparam int CW = $clog2(2 * CLKS_PER_BIT + 1);

    state_t        state, state_nx;
    logic [3:0]    pid;
    logic [6:0]    rem;
    logic [15:0]   crc;
    logic [CW-1:0] cnt;
    logic          is_data, pop, abort;

    assign is_data = (pid[1:0] == 2'b11);

`ifdef USB_TX_ABORT_EN
    assign abort = bus.tx_abort &&
                   (state inside {S_SYNC, S_PID, S_DATA, S_CRCL, S_LAST});
`else
    assign abort = 1'b0;
`endif

    // A FIFO byte is consumed exactly when the transmitter reloads from it.
    assign pop         = bus.byte_done && (bus.select == 2'd0) &&
                         (state inside {S_PID, S_DATA}) && !abort;
    assign bus.fifo_rd = pop && !rst;

    // Reflected CRC16 (poly A001), one byte folded LSB-first.
    function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // State register plus clock counter that restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? '0 : cnt + 1'b1;
        end
    end

    // Next-state: advance on byte_done while framing, on bit timing in EOP/J.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.tx_start) state_nx = S_LOAD;
            S_LOAD: state_nx = S_SYNC;
            S_SYNC: if (bus.byte_done) state_nx = S_PID;
            S_PID:  if (bus.byte_done) begin
                        if (!is_data)      state_nx = S_LAST;
                        else if (rem != 0) state_nx = S_DATA;
                        else               state_nx = S_CRCL;
                    end
            S_DATA: if (bus.byte_done && rem == 0) state_nx = S_CRCL;
            S_CRCL: if (bus.byte_done) state_nx = S_LAST;
            S_LAST: if (bus.byte_done) state_nx = S_EOP;
            S_EOP:  if (cnt == CW'(2 * CLKS_PER_BIT - 1)) state_nx = S_J;
            S_J:    if (cnt == CW'(CLKS_PER_BIT - 1)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_EOP;
    end

    // Moore outputs toward the byte transmitter and line encoder.
    always_comb begin
        bus.select      = 2'd0;
        bus.fsm_byte    = 8'h00;
        bus.load_en     = 1'b0;
        bus.tim_rst     = 1'b0;
        bus.tim_en      = 1'b0;
        bus.eop         = 1'b0;
        bus.idle        = 1'b0;
        bus.eop_new_bit = 1'b0;
        case (state)
            S_IDLE: bus.idle = 1'b1;
            S_LOAD: begin
                bus.select   = 2'd1;
                bus.fsm_byte = 8'h80;
                bus.load_en  = 1'b1;
                bus.tim_rst  = 1'b1;
            end
            S_SYNC: begin
                bus.tim_en   = 1'b1;
                bus.select   = 2'd1;
                bus.fsm_byte = {~pid, pid};
            end
            S_PID: begin
                bus.tim_en = 1'b1;
                if (is_data) bus.select = (rem != 0) ? 2'd0 : 2'd2;
                else begin
                    // PID-only packet: nothing further to load
                    bus.select   = 2'd1;
                    bus.fsm_byte = {~pid, pid};
                end
            end
            S_DATA: begin
                bus.tim_en = 1'b1;
                bus.select = (rem != 0) ? 2'd0 : 2'd2;
            end
            S_CRCL: begin
                bus.tim_en = 1'b1;
                bus.select = 2'd3;
            end
            S_LAST: begin
                // last byte shifting; the reload this triggers is discarded
                bus.tim_en   = 1'b1;
                bus.select   = 2'd1;
                bus.fsm_byte = {~pid, pid};
            end
            S_EOP: begin
                bus.eop         = 1'b1;
                bus.eop_new_bit = (cnt == '0) || (cnt == CW'(CLKS_PER_BIT));
            end
            S_J: begin
                bus.idle        = 1'b1;
                bus.eop_new_bit = (cnt == '0);
            end
            default: bus.idle = 1'b1;
        endcase
    end

    // Request latch, payload countdown, CRC accumulation and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pid           <= 4'h0;
            rem           <= 7'd0;
            crc           <= 16'hFFFF;
            bus.crc_bytes <= 16'h0000;
            bus.tx_busy   <= 1'b0;
            bus.tx_done   <= 1'b0;
        end else begin
            bus.crc_bytes <= ~crc;
            bus.tx_done   <= (state == S_J) && (state_nx == S_IDLE);
            if (state == S_IDLE && bus.tx_start) begin
                pid         <= bus.tx_pid;
                rem         <= (bus.tx_len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : bus.tx_len;
                crc         <= 16'hFFFF;
                bus.tx_busy <= 1'b1;
            end
            if (pop) begin
                crc <= crc_fold(crc, bus.fifo_byte);
                rem <= rem - 7'd1;
            end
            if (state == S_J && state_nx == S_IDLE) bus.tx_busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_usb_tx_packet_ctrl.sv
// Directed bench for usb_tx_packet_ctrl: table of packet requests with
// expected framing results, plus hand-written reset and abort sequences.
module tb_usb_tx_packet_ctrl;
    localparam int CPB = 8;
    localparam int P   = 12;   // clocks between byte_done pulses

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_tx_packet_ctrl_if bus();
    usb_tx_packet_ctrl #(.CLKS_PER_BIT(CPB), .MAX_LEN(64)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk = 0, n_pass = 0;

    // FIFO model: head byte is a running counter, popped on fifo_rd
    logic [7:0] rd_ptr = 8'h00;
    always @(posedge clk) if (bus.fifo_rd) rd_ptr <= rd_ptr + 8'd1;
    assign bus.fifo_byte = rd_ptr;

    // Monitor: cumulative event counters and a log of loaded bytes
    int n_rd = 0, n_eop = 0, n_jidle = 0, n_done = 0, n_nb = 0, n_mis = 0, n_blow = 0;
    bit in_pkt = 1'b0;
    logic [7:0] ldq[$];
    always @(negedge clk) begin
        if (bus.fifo_rd) n_rd++;
        if (bus.fifo_rd && !bus.byte_done) n_mis++;
        if (bus.eop) n_eop++;
        if (bus.idle && bus.tx_busy) n_jidle++;
        if (bus.tx_done) n_done++;
        if (bus.eop_new_bit) n_nb++;
        if (in_pkt && !bus.tx_busy && !bus.tx_done) n_blow++;
        if (bus.load_en) ldq.push_back(bus.fsm_byte);
        if (bus.byte_done)
            case (bus.select)
                2'd0: ldq.push_back(bus.fifo_byte);
                2'd1: ldq.push_back(bus.fsm_byte);
                2'd2: ldq.push_back(bus.crc_bytes[7:0]);
                default: ldq.push_back(bus.crc_bytes[15:8]);
            endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Bitwise reference CRC over consecutive bytes start, start+1, ...
    function automatic logic [15:0] crc_ref(input logic [7:0] start, input int n);
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            d = start + 8'(i);
            for (int b = 0; b < 8; b++) begin
                fb = d[b] ^ c[0];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic start_pkt(input logic [3:0] pid, input logic [6:0] len);
        @(posedge clk); #1;
        bus.tx_start = 1'b1; bus.tx_pid = pid; bus.tx_len = len;
        @(posedge clk); #1;
        bus.tx_start = 1'b0; bus.tx_pid = 4'h0; bus.tx_len = 7'd0;
        in_pkt = 1'b1;
    endtask

    task automatic pulse_bd(input bit mid);
        repeat (P - 1) @(posedge clk);
        #1 bus.byte_done = 1'b1;
        if (mid) begin bus.tx_start = 1'b1; bus.tx_pid = 4'b0010; bus.tx_len = 7'd3; end
        @(posedge clk); #1;
        bus.byte_done = 1'b0; bus.tx_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (n_done == d0 && t < 400) begin @(posedge clk); t++; end
        chk("done_timeout", (t < 400), 1);
        in_pkt = 1'b0;
    endtask

    typedef struct {
        logic [3:0] pid;
        logic [6:0] len;
        logic [7:0] pidb;   // expected PID byte on the wire
        int         bd;     // byte_done pulses until EOP
        int         rd;     // expected fifo_rd pulses
        bit         data;
        bit         mid;    // pulse tx_start mid-packet
    } vec_t;

    vec_t vt[6];

    initial begin
        int base, rd0, eop0, j0, d0, nb0, mis0, bl0, bd, t, bad, n;
        logic [7:0] p0;
        logic [15:0] cr;

        vt[0] = '{4'b0010, 7'd5,   8'hD2, 3,  0,  1'b0, 1'b0};  // ACK
        vt[1] = '{4'b0011, 7'd0,   8'hC3, 4,  0,  1'b1, 1'b0};  // DATA0 empty
        vt[2] = '{4'b1011, 7'd4,   8'h4B, 8,  4,  1'b1, 1'b0};  // DATA1 x4
        vt[3] = '{4'b0011, 7'd100, 8'hC3, 68, 64, 1'b1, 1'b1};  // saturates
        vt[4] = '{4'b1010, 7'd0,   8'h5A, 3,  0,  1'b0, 1'b0};  // NAK
        vt[5] = '{4'b0111, 7'd1,   8'h87, 5,  1,  1'b1, 1'b0};  // DATA2 x1

        bus.tx_start = 1'b0; bus.tx_pid = 4'h0; bus.tx_len = 7'd0; bus.byte_done = 1'b0;
`ifdef USB_TX_ABORT_EN
        bus.tx_abort = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", bus.idle, 1);
        chk("rst_ctrl", {bus.load_en, bus.tim_rst, bus.tim_en, bus.eop, bus.eop_new_bit, bus.fifo_rd}, 0);
        chk("rst_sel", {bus.select, bus.fsm_byte}, 0);
        chk("rst_stat", {bus.tx_busy, bus.tx_done}, 0);
        chk("rst_crc", bus.crc_bytes, 16'h0000);

        // byte_done in IDLE does nothing
        rd0 = n_rd;
        pulse_bd(1'b0);
        @(negedge clk);
        chk("idle_bd_rd", n_rd - rd0, 0);
        chk("idle_bd_busy", bus.tx_busy, 0);

        // reset during payload byte 10
        rd0 = n_rd; d0 = n_done;
        start_pkt(4'b0011, 7'd20);
        t = 0;
        while (n_rd - rd0 < 10 && t < 40) begin pulse_bd(1'b0); t++; end
        chk("pre_rst_rd", n_rd - rd0, 10);
        repeat (P - 1) @(posedge clk);
        #1 bus.byte_done = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_no_rd", bus.fifo_rd, 0);
        @(posedge clk); #1 bus.byte_done = 1'b0; rst = 1'b0;
        in_pkt = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", {bus.idle, bus.tim_en, bus.tx_busy, bus.tx_done}, 4'b1000);
        chk("rst_mid_rd", n_rd - rd0, 10);
        chk("rst_mid_done", n_done - d0, 0);

        // table of normal packets
        for (int v = 0; v < 6; v++) begin
            base = ldq.size(); rd0 = n_rd; eop0 = n_eop; j0 = n_jidle;
            d0 = n_done; nb0 = n_nb; mis0 = n_mis; bl0 = n_blow; p0 = rd_ptr;
            start_pkt(vt[v].pid, vt[v].len);
            bd = 0; t = 0;
            while (!bus.eop && t < 200) begin
                pulse_bd(vt[v].mid && bd == 10);
                bd++; t++;
            end
            wait_done(d0);
            repeat (3) @(posedge clk);
            chk($sformatf("v%0d_bd", v), bd, vt[v].bd);
            chk($sformatf("v%0d_rd", v), n_rd - rd0, vt[v].rd);
            chk($sformatf("v%0d_eop", v), n_eop - eop0, 2 * CPB);
            chk($sformatf("v%0d_j", v), n_jidle - j0, CPB);
            chk($sformatf("v%0d_done", v), n_done - d0, 1);
            chk($sformatf("v%0d_nb", v), n_nb - nb0, 3);
            chk($sformatf("v%0d_align", v), n_mis - mis0, 0);
            chk($sformatf("v%0d_busy", v), n_blow - bl0, 0);
            chk($sformatf("v%0d_idle_after", v), bus.tx_busy, 0);
            chk($sformatf("v%0d_sync", v), ldq[base], 8'h80);
            chk($sformatf("v%0d_pid", v), ldq[base + 1], vt[v].pidb);
            if (vt[v].data) begin
                n = vt[v].rd; bad = 0;
                for (int i = 0; i < n; i++)
                    if (ldq[base + 2 + i] !== p0 + 8'(i)) bad++;
                chk($sformatf("v%0d_payload", v), bad, 0);
                cr = crc_ref(p0, n);
                chk($sformatf("v%0d_crc", v), {ldq[base + 3 + n], ldq[base + 2 + n]}, cr);
            end
        end

`ifdef USB_TX_ABORT_EN
        // abort after the third payload byte of eight
        rd0 = n_rd; eop0 = n_eop; d0 = n_done; t = 0;
        start_pkt(4'b1011, 7'd8);
        while (n_rd - rd0 < 3 && t < 20) begin pulse_bd(1'b0); t++; end
        @(posedge clk); #1 bus.tx_abort = 1'b1;
        @(posedge clk); #1 bus.tx_abort = 1'b0;
        chk("abort_eop", {bus.eop, bus.tim_en}, 2'b10);
        wait_done(d0);
        chk("abort_rd", n_rd - rd0, 3);
        chk("abort_eop_len", n_eop - eop0, 2 * CPB);
        chk("abort_done", n_done - d0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
